// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared widths and enumerations for the IF/LS memory arbiter.
//               ADDR_W_DEF / DATA_W_DEF : default address / data widths
//               state_e                 : arbiter FSM states
//               owner_e                 : which requester owns a grant
// Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_arb_sel.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_sel
// Description : Grant selection for the memory arbiter. LS wins over IF
//               unless LS has already taken MAX_LS_STREAK grants in a row
//               while IF was waiting.
//   clk, reset   : clock, synchronous active-high reset
//   idle_i       : arbiter is idle and may grant this cycle
//   if_req_i     : instruction-fetch request pending
//   ls_req_i     : load/store request pending
//   gnt_valid_o  : a grant is issued this cycle (combinational)
//   gnt_owner_o  : requester receiving the grant
// Revision    : 1.0  initial release
// ============================================================================
module mem_arb_sel
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   idle_i,
  input  logic   if_req_i,
  input  logic   ls_req_i,
  output logic   gnt_valid_o,
  output owner_e gnt_owner_o
);

  localparam int unsigned SW = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

  logic [SW-1:0] streak_q;
  logic [SW-1:0] streak_d;
  logic          grant_if;
  logic          grant_ls;

  // Grants are suppressed during reset so no requester sees a phantom accept.
  always_comb begin
    grant_if    = idle_i & ~reset & if_req_i & (~ls_req_i | (streak_q == STREAK_MAX));
    grant_ls    = idle_i & ~reset & ls_req_i & ~grant_if;
    gnt_valid_o = grant_if | grant_ls;
    gnt_owner_o = grant_ls ? OWN_LS : OWN_IF;
  end

  // Streak only moves on a grant edge; it counts LS grants that overtook a
  // waiting IF request.
  always_comb begin
    streak_d = streak_q;
    if (grant_if) begin
      streak_d = '0;
    end else if (grant_ls) begin
      if (!if_req_i) begin
        streak_d = '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-port memory between the IF and LS units.
//               One transaction outstanding at a time, variable-latency
//               req/ready handshake towards memory, done pulse back to owner.
//   clk, reset                          : clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt            : IF read request and accept
//   if_done/if_rdata                    : IF completion pulse and fetched word
//   ls_req/ls_we/ls_be/ls_addr/ls_wdata : LS command
//   ls_gnt, ls_done/ls_rdata            : LS accept, completion and load data
//   mem_req/we/be/addr/wdata            : registered memory command
//   mem_ready/mem_rdata                 : memory completion and read data
// Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_done,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_done,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_e              state_q,     state_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [BE_W-1:0]     mem_be_q,    mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_done_q,   if_done_d;
  logic                ls_done_q,   ls_done_d;
  logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0]   ls_rdata_q,  ls_rdata_d;

  logic   gnt_valid;
  owner_e gnt_owner;

  mem_arb_sel #(
    .MAX_LS_STREAK (MAX_LS_STREAK)
  ) u_sel (
    .clk         (clk),
    .reset       (reset),
    .idle_i      (state_q == IDLE),
    .if_req_i    (if_req),
    .ls_req_i    (ls_req),
    .gnt_valid_o (gnt_valid),
    .gnt_owner_o (gnt_owner)
  );

  assign if_gnt = gnt_valid & (gnt_owner == OWN_IF);
  assign ls_gnt = gnt_valid & (gnt_owner == OWN_LS);

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;

    case (state_q)
      IDLE: begin
        // mem_ready arriving here belongs to no transaction and is ignored.
        if (if_gnt) begin
          state_d    = BUSY_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_be_d   = '1;
          mem_addr_d = if_addr;
        end else if (ls_gnt) begin
          state_d     = BUSY_LS;
          mem_req_d   = 1'b1;
          mem_we_d    = ls_we;
          mem_be_d    = ls_be;
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
        end
      end
      BUSY_IF: begin
        if (mem_ready) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          if_rdata_d = mem_rdata;
          if_done_d  = 1'b1;
        end
      end
      BUSY_LS: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          ls_done_d = 1'b1;
          // Write completions leave the last load data untouched.
          if (!mem_we_q) begin
            ls_rdata_d = mem_rdata;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      ls_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      ls_done_q   <= ls_done_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign ls_done   = ls_done_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter. Inputs change
//               1 ns after a rising edge; outputs are checked 2 ns after it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int total;
  int bad;

  mem_arbiter #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .MAX_LS_STREAK (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_be     (ls_be),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_done   (ls_done),
    .ls_rdata  (ls_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = 0;
    ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; if_req = 1; ls_req = 1;
    #1;
    total++;
    if ({if_gnt, ls_gnt} !== 2'b00) begin
      bad++; $display("FAIL reset_gnt got=%b want=00", {if_gnt, ls_gnt});
    end
    tick();
    tick();
    #1;
    total++;
    if ({mem_req, mem_we, if_done, ls_done, mem_be} !== 8'h00) begin
      bad++; $display("FAIL reset_ctrl got=%h want=00", {mem_req, mem_we, if_done, ls_done, mem_be});
    end
    total++;
    if ({mem_addr, mem_wdata, if_rdata, ls_rdata} !== 128'd0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {mem_addr, mem_wdata, if_rdata, ls_rdata});
    end
    reset = 0; if_req = 0; ls_req = 0;
  endtask

  task automatic test_if_read();
    do_reset();
    if_req = 1; if_addr = 32'h10;
    #1;
    total++;
    if ({if_gnt, ls_gnt} !== 2'b10) begin
      bad++; $display("FAIL if_read_gnt got=%b want=10", {if_gnt, ls_gnt});
    end
    tick();
    if_req = 0; mem_ready = 1; mem_rdata = 32'h0050_0093;
    #1;
    total++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h10}) begin
      bad++; $display("FAIL if_read_cmd got=%h want=%h", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 4'hF, 32'h10});
    end
    tick();
    mem_ready = 0; mem_rdata = 0;
    #1;
    total++;
    if ({if_done, ls_done, mem_req, if_rdata} !== {3'b100, 32'h0050_0093}) begin
      bad++; $display("FAIL if_read_done got=%h want=%h", {if_done, ls_done, mem_req, if_rdata}, {3'b100, 32'h0050_0093});
    end
    tick();
    #1;
    total++;
    if (if_done !== 1'b0) begin
      bad++; $display("FAIL if_read_pulse got=%b want=0", if_done);
    end
  endtask

  task automatic test_priority();
    do_reset();
    if_req = 1; if_addr = 32'h200;
    ls_req = 1; ls_we = 1; ls_addr = 32'h100; ls_wdata = 32'hDEAD_BEEF; ls_be = 4'b0011;
    #1;
    total++;
    if ({if_gnt, ls_gnt} !== 2'b01) begin
      bad++; $display("FAIL prio_gnt got=%b want=01", {if_gnt, ls_gnt});
    end
    tick();
    ls_req = 0; mem_ready = 1; mem_rdata = 32'h1111_2222;
    #1;
    total++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL prio_ls_cmd got=%h want=%h", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'b0011, 32'h100, 32'hDEAD_BEEF});
    end
    total++;
    if ({if_gnt, ls_gnt} !== 2'b00) begin
      bad++; $display("FAIL prio_busy_gnt got=%b want=00", {if_gnt, ls_gnt});
    end
    tick();
    mem_ready = 0;
    #1;
    total++;
    if ({ls_done, if_done, if_gnt, ls_rdata} !== {3'b101, 32'h0}) begin
      bad++; $display("FAIL prio_done_ifgnt got=%h want=%h", {ls_done, if_done, if_gnt, ls_rdata}, {3'b101, 32'h0});
    end
    tick();
    if_req = 0; mem_ready = 1; mem_rdata = 32'hABCD_0001;
    #1;
    total++;
    if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h200}) begin
      bad++; $display("FAIL prio_if_cmd got=%h want=%h", {mem_req, mem_we, mem_be, mem_addr}, {1'b1, 1'b0, 4'hF, 32'h200});
    end
    tick();
    mem_ready = 0;
    #1;
    total++;
    if ({if_done, if_rdata} !== {1'b1, 32'hABCD_0001}) begin
      bad++; $display("FAIL prio_if_done got=%h want=%h", {if_done, if_rdata}, {1'b1, 32'hABCD_0001});
    end
  endtask

  // With both requests held and an instant memory, grants alternate with
  // busy cycles: four LS, one IF, then four LS again (streak restarted).
  task automatic test_streak();
    logic [9:0] exp_if;
    do_reset();
    exp_if = 10'b10000_10000; // bit k = grant k goes to IF
    if_req = 1; if_addr = 32'h300;
    ls_req = 1; ls_we = 0; ls_be = 4'hF; ls_addr = 32'h400;
    mem_ready = 1; mem_rdata = 32'h5555_AAAA;
    for (int k = 0; k < 10; k++) begin
      #1;
      total++;
      if ({if_gnt, ls_gnt} !== {exp_if[k], ~exp_if[k]}) begin
        bad++; $display("FAIL streak_gnt%0d got=%b want=%b", k, {if_gnt, ls_gnt}, {exp_if[k], ~exp_if[k]});
      end
      tick();
      #1;
      total++;
      if ({if_gnt, ls_gnt} !== 2'b00) begin
        bad++; $display("FAIL streak_busy%0d got=%b want=00", k, {if_gnt, ls_gnt});
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_delayed_ready();
    do_reset();
    ls_req = 1; ls_we = 0; ls_be = 4'hF; ls_addr = 32'h80;
    #1;
    total++;
    if (ls_gnt !== 1'b1) begin
      bad++; $display("FAIL delay_gnt got=%b want=1", ls_gnt);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      ls_req = 0;
      if_req = (i != 3);
      if_addr = 32'h44;
      mem_ready = (i == 3);
      mem_rdata = (i == 3) ? 32'h1234_5678 : 32'hFFFF_FFFF;
      #1;
      total++;
      if ({mem_req, mem_we, mem_be, mem_addr, if_gnt, ls_gnt, ls_done} !== {1'b1, 1'b0, 4'hF, 32'h80, 3'b000}) begin
        bad++; $display("FAIL delay_busy%0d got=%h want=%h", i, {mem_req, mem_we, mem_be, mem_addr, if_gnt, ls_gnt, ls_done}, {1'b1, 1'b0, 4'hF, 32'h80, 3'b000});
      end
    end
    tick();
    mem_ready = 0; mem_rdata = 0;
    #1;
    total++;
    if ({ls_done, if_done, mem_req, ls_rdata} !== {3'b100, 32'h1234_5678}) begin
      bad++; $display("FAIL delay_done got=%h want=%h", {ls_done, if_done, mem_req, ls_rdata}, {3'b100, 32'h1234_5678});
    end
    tick();
    #1;
    total++;
    if ({ls_done, ls_rdata} !== {1'b0, 32'h1234_5678}) begin
      bad++; $display("FAIL delay_pulse got=%h want=%h", {ls_done, ls_rdata}, {1'b0, 32'h1234_5678});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ls_req = 1; ls_we = 0; ls_be = 4'hF; ls_addr = 32'h44;
    tick();
    ls_req = 0;
    #1;
    total++;
    if (mem_req !== 1'b1) begin
      bad++; $display("FAIL rmid_busy got=%b want=1", mem_req);
    end
    tick();
    reset = 1; mem_ready = 1; mem_rdata = 32'h9999_9999;
    tick();
    reset = 0; mem_ready = 0; mem_rdata = 0;
    #1;
    total++;
    if ({mem_req, ls_done, if_done, ls_rdata} !== {3'b000, 32'h0}) begin
      bad++; $display("FAIL rmid_abandon got=%h want=0", {mem_req, ls_done, if_done, ls_rdata});
    end
    if_req = 1; if_addr = 32'h20;
    #1;
    total++;
    if (if_gnt !== 1'b1) begin
      bad++; $display("FAIL rmid_if_gnt got=%b want=1", if_gnt);
    end
    tick();
    if_req = 0; mem_ready = 1; mem_rdata = 32'h0000_CAFE;
    #1;
    total++;
    if ({mem_req, mem_addr, ls_done} !== {1'b1, 32'h20, 1'b0}) begin
      bad++; $display("FAIL rmid_if_cmd got=%h want=%h", {mem_req, mem_addr, ls_done}, {1'b1, 32'h20, 1'b0});
    end
    tick();
    mem_ready = 0;
    #1;
    total++;
    if ({if_done, ls_done, if_rdata} !== {2'b10, 32'h0000_CAFE}) begin
      bad++; $display("FAIL rmid_if_done got=%h want=%h", {if_done, ls_done, if_rdata}, {2'b10, 32'h0000_CAFE});
    end
  endtask

  // Relies on if_rdata = 0x0000CAFE and ls_rdata = 0 left by test_reset_mid.
  task automatic test_idle_ready();
    tick();
    mem_ready = 1; mem_rdata = 32'hBADB_AD00;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      total++;
      if ({if_done, ls_done, mem_req, if_rdata, ls_rdata} !== {3'b000, 32'h0000_CAFE, 32'h0}) begin
        bad++; $display("FAIL idle_ready%0d got=%h want=%h", i, {if_done, ls_done, mem_req, if_rdata, ls_rdata}, {3'b000, 32'h0000_CAFE, 32'h0});
      end
    end
    mem_ready = 0; mem_rdata = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1;
    idle_inputs();
    test_reset();
    test_if_read();
    test_priority();
    test_streak();
    test_delayed_ready();
    test_reset_mid();
    test_idle_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
